// File: rtl/lr35902_oam_dma_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lr35902_oam_dma_pkg : shared constants and state encoding for the OAM DMA
// Rev 1.0
// ----------------------------------------------------------------------------
package lr35902_oam_dma_pkg;

    localparam logic [3:0] DMA_REG_OFS  = 4'h6;
    localparam int         OAM_SIZE     = 160;
    localparam logic [7:0] VRAM_PAGE_LO = 8'h80;
    localparam logic [7:0] VRAM_PAGE_HI = 8'h9F;
    localparam logic [7:0] ECHO_PAGE_LO = 8'hE0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/lr35902_oam_dma.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lr35902_oam_dma : copies one 160-byte page into OAM after a write to 0xFF46
// Rev 1.0
// ----------------------------------------------------------------------------
module lr35902_oam_dma
    import lr35902_oam_dma_pkg::*;
#(
    parameter int NBYTES      = OAM_SIZE,
    parameter int TPB         = 4,
    parameter int START_DELAY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write,
    input  logic        reg_read,
    input  logic [7:0]  reg_din,
    output logic [7:0]  reg_dout,
    output logic [15:0] adr_dma_rd,
    output logic        rd_dma,
    input  logic [7:0]  data_dma_in,
    output logic [7:0]  adr_dma_wr,
    output logic        wr_dma,
    output logic [7:0]  data_dma_out,
    output logic        dma_active,
    output logic        dma_drvext
);

    localparam int PH_W  = (TPB > 1) ? $clog2(TPB) : 1;
    localparam int CNT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(TPB - 1);
    localparam logic [PH_W-1:0]  PH_LATCH = PH_W'(TPB - 2);
    localparam logic [7:0]       IDX_LAST = 8'(NBYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(START_DELAY - 1);

    // Echo RAM (0xE0..0xFF) aliases WRAM, so the page drops bit 5.
    function automatic logic [7:0] map_page(input logic [7:0] page);
        return (page >= ECHO_PAGE_LO) ? (page & 8'hDF) : page;
    endfunction

    function automatic logic is_vram(input logic [7:0] page);
        return (page >= VRAM_PAGE_LO) && (page <= VRAM_PAGE_HI);
    endfunction

    dma_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       idx, idx_n;
    logic [PH_W-1:0]  ph, ph_n;
    logic [7:0]       src_raw, src_n;
    logic [7:0]       src_map;
    logic             xfer_n;
    logic             unused_read;

    assign unused_read = reg_read;
    assign src_map     = map_page(src_raw);
    assign reg_dout    = src_raw;
    assign dma_drvext  = (state != IDLE) && !is_vram(src_map);
    assign xfer_n      = (state_n == XFER);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        ph_n    = ph;
        src_n   = src_raw;
        if (reg_write) begin
            // A write in any state (re)starts from scratch with a full delay.
            src_n   = reg_din;
            state_n = START;
            cnt_n   = CNT_LOAD;
            idx_n   = '0;
            ph_n    = '0;
        end else begin
            case (state)
                START: begin
                    if (cnt == '0) begin
                        state_n = XFER;
                        idx_n   = '0;
                        ph_n    = '0;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                XFER: begin
                    if (ph == PH_LAST) begin
                        ph_n = '0;
                        if (idx == IDX_LAST) begin
                            state_n = IDLE;
                        end else begin
                            idx_n = idx + 8'd1;
                        end
                    end else begin
                        ph_n = ph + PH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes and addresses are registered from the next-state values so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            ph           <= '0;
            src_raw      <= 8'h00;
            adr_dma_rd   <= 16'h0000;
            adr_dma_wr   <= 8'h00;
            data_dma_out <= 8'h00;
            rd_dma       <= 1'b0;
            wr_dma       <= 1'b0;
            dma_active   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            ph         <= ph_n;
            src_raw    <= src_n;
            dma_active <= (state_n != IDLE);
            rd_dma     <= xfer_n && (ph_n != PH_LAST);
            wr_dma     <= xfer_n && (ph_n == PH_LAST);
            if (xfer_n) begin
                adr_dma_rd <= {src_map, idx_n};
            end
            if (xfer_n && (ph_n == PH_LAST)) begin
                adr_dma_wr <= idx_n;
            end
            if ((state == XFER) && (ph == PH_LATCH)) begin
                data_dma_out <= data_dma_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lr35902_oam_dma.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lr35902_oam_dma : directed bench for the OAM DMA engine
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_lr35902_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic        reg_read;
    logic [7:0]  reg_din;
    logic [7:0]  reg_dout;
    logic [15:0] adr_dma_rd;
    logic        rd_dma;
    logic [7:0]  data_dma_in;
    logic [7:0]  adr_dma_wr;
    logic        wr_dma;
    logic [7:0]  data_dma_out;
    logic        dma_active;
    logic        dma_drvext;

    logic [7:0] src_mem [0:65535];
    logic [7:0] oam     [0:255];
    logic       oam_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lr35902_oam_dma dut (
        .clk          (clk),
        .reset        (reset),
        .reg_write    (reg_write),
        .reg_read     (reg_read),
        .reg_din      (reg_din),
        .reg_dout     (reg_dout),
        .adr_dma_rd   (adr_dma_rd),
        .rd_dma       (rd_dma),
        .data_dma_in  (data_dma_in),
        .adr_dma_wr   (adr_dma_wr),
        .wr_dma       (wr_dma),
        .data_dma_out (data_dma_out),
        .dma_active   (dma_active),
        .dma_drvext   (dma_drvext)
    );

    assign data_dma_in = src_mem[adr_dma_rd];

    always @(posedge clk) begin
        if (oam_clr) begin
            for (int i = 0; i < 256; i++) oam[i] <= 8'hEE;
        end else if (wr_dma) begin
            oam[adr_dma_wr] <= data_dma_out;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] eff_page(input logic [7:0] page);
        return (page >= 8'hE0) ? page - 8'h20 : page;
    endfunction

    // Runs one transfer, optionally rewriting the register or pulsing reset at
    // cycle k (k=0 is the first sample after the write edge).
    task automatic run_xfer(input string tag, input logic [7:0] page,
                            input int restart_at, input logic [7:0] page2,
                            input int reset_at, input int exp_nwr);
        int origin, first_rd, fall, nwr, errs, drv_errs, oam_errs;
        int rel, x, idx, ph;
        logic [7:0]  base, first_base;
        logic [15:0] first_adr;
        logic        exp_drv;
        origin = 0; first_rd = -1; fall = -1; nwr = 0; errs = 0; drv_errs = 0;
        first_adr = 16'hFFFF;
        base = eff_page(page);
        first_base = base;
        reg_din = page;
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        chk({tag, "_active_rise"}, dma_active, 1);
        for (int k = 0; k < 1400; k++) begin
            rel = k - origin;
            if (!dma_active) begin
                fall = rel;
                break;
            end
            exp_drv = !(base >= 8'h80 && base <= 8'h9F);
            if (dma_drvext !== exp_drv) drv_errs++;
            if (rd_dma && first_rd < 0) begin
                first_rd = rel;
                first_adr = adr_dma_rd;
            end
            if (rel < 4) begin
                if (rd_dma || wr_dma) errs++;
            end else begin
                x = rel - 4;
                idx = x / 4;
                ph = x % 4;
                if (rd_dma !== (ph != 3) || wr_dma !== (ph == 3)) errs++;
                if (rd_dma && adr_dma_rd !== {base, 8'(idx)}) errs++;
                if (wr_dma) begin
                    nwr++;
                    if (adr_dma_wr !== 8'(idx)) errs++;
                    if (data_dma_out !== src_mem[{base, 8'(idx)}]) errs++;
                end
            end
            if (k == reset_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk({tag, "_rst_outs_a"}, {reg_dout, adr_dma_rd, adr_dma_wr}, 0);
                chk({tag, "_rst_outs_b"},
                    {data_dma_out, rd_dma, wr_dma, dma_active, dma_drvext}, 0);
                tick();
                chk({tag, "_rst_idle"}, {rd_dma, wr_dma, dma_active, dma_drvext}, 0);
                break;
            end
            reg_write = (k == restart_at);
            reg_din = page2;
            tick();
            reg_write = 1'b0;
            if (k == restart_at) begin
                origin = k + 1;
                base = eff_page(page2);
            end
        end
        chk({tag, "_first_rd_k"}, first_rd, 4);
        chk({tag, "_first_rd_adr"}, first_adr, {first_base, 8'h00});
        chk({tag, "_nwr"}, nwr, exp_nwr);
        chk({tag, "_seq_errs"}, errs, 0);
        chk({tag, "_drvext_errs"}, drv_errs, 0);
        oam_errs = 0;
        if (reset_at >= 0) begin
            for (int i = 0; i < 160; i++) begin
                if (i < reset_at / 4 - 1 && oam[i] !== src_mem[{base, 8'(i)}]) oam_errs++;
                if (i >= reset_at / 4 - 1 && oam[i] !== 8'hEE) oam_errs++;
            end
        end else begin
            chk({tag, "_fall_k"}, fall, 644);
            chk({tag, "_hold_adr"}, {adr_dma_rd, adr_dma_wr}, {base, 8'h9F, 8'h9F});
            chk({tag, "_idle_strobes"}, {rd_dma, wr_dma, dma_drvext}, 0);
            for (int i = 0; i < 160; i++)
                if (oam[i] !== src_mem[{base, 8'(i)}]) oam_errs++;
        end
        chk({tag, "_oam_errs"}, oam_errs, 0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            src_mem[a] = 8'(a[15:8] + a[7:0] + 8'h33);
        end
        for (int i = 0; i < 256; i++) begin
            src_mem[{8'hC0, 8'(i)}] = 8'(i) ^ 8'h5A;
            src_mem[{8'h80, 8'(i)}] = 8'(i) + 8'h11;
            src_mem[{8'hDE, 8'(i)}] = ~8'(i);
            src_mem[{8'hFE, 8'(i)}] = 8'hBD;
            src_mem[{8'hD0, 8'(i)}] = 8'(i) ^ 8'hA5;
            src_mem[{8'h00, 8'(i)}] = 8'(i * 3);
        end
        reset = 1'b1; reg_write = 1'b0; reg_read = 1'b0; reg_din = 8'h00; oam_clr = 1'b1;
        tick();
        tick();
        chk("reset_outs_a", {reg_dout, adr_dma_rd, adr_dma_wr}, 0);
        chk("reset_outs_b", {data_dma_out, rd_dma, wr_dma, dma_active, dma_drvext}, 0);
        reset = 1'b0;
        oam_clr = 1'b0;
        tick();

        run_xfer("wram_c0", 8'hC0, -1, 8'h00, -1, 160);
        run_xfer("vram_80", 8'h80, -1, 8'h00, -1, 160);
        reg_read = 1'b1;
        run_xfer("echo_fe", 8'hFE, -1, 8'h00, -1, 160);
        chk("reg_dout_fe", reg_dout, 8'hFE);
        reg_read = 1'b0;
        chk("reg_dout_noread", reg_dout, 8'hFE);
        run_xfer("restart_d0", 8'hC0, 4 + 50 * 4 + 1, 8'hD0, -1, 50 + 160);

        oam_clr = 1'b1;
        tick();
        oam_clr = 1'b0;
        run_xfer("reset_mid", 8'hC0, -1, 8'h00, 4 + 80 * 4, 80);
        chk("reset_mid_dout", reg_dout, 8'h00);

        run_xfer("page_00", 8'h00, -1, 8'h00, -1, 160);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lr35902_oam_dma.md
Name: lr35902_oam_dma

Overview:
- OAM DMA engine that drives the adr_dma_rd, adr_dma_wr, rd_dma, wr_dma, data_dma_out, dma_active and dma_drvext nets into the video top's OAM and VRAM muxing, replacing the current tie-offs.
- A CPU write to the DMA register (0xFF46) with value XX starts a copy of 160 bytes: source XX00..XX9F, destination OAM 0x00..0x9F.
- While active, the block owns OAM. It also owns the external bus whenever the source is outside VRAM.

Parameters:
- NBYTES, 160, number of bytes per transfer (OAM size).
- TPB, 4, clocks per byte (one machine cycle at 4 MiHz).
- START_DELAY, 4, clocks from the register write to the first source read.

Ports:
- clk  in  1  gbclk, 4 MiHz.
- reset  in  1  synchronous, active-high.
- reg_write  in  1  write strobe; already qualified by the 0xFF46 select externally.
- reg_read  in  1  read strobe (qualified externally).
- reg_din  in  8  CPU write data.
- reg_dout  out  8  last written source page.
- adr_dma_rd  out  16  source address.
- rd_dma  out  1  source read strobe.
- data_dma_in  in  8  source read data (VRAM or external bus, muxed upstream).
- adr_dma_wr  out  8  OAM destination address.
- wr_dma  out  1  OAM write strobe.
- data_dma_out  out  8  OAM write data.
- dma_active  out  1  the DMA owns OAM.
- dma_drvext  out  1  the DMA drives the external address bus and n_read.

Behaviour:
- Reset (already decided): one clock, clk; reset is synchronous and active-high. Reset clears every register and output:
  - reg_dout=0x00, adr_dma_rd=0x0000, adr_dma_wr=0x00, data_dma_out=0x00.
  - rd_dma=0, wr_dma=0, dma_active=0, dma_drvext=0.
  - State returns to IDLE. Reset mid-transfer aborts at once; OAM keeps the bytes already written.
- Source page: src = reg_din on write. Any page value >= 0xE0 is mapped to src & 0xDF (echo RAM into WRAM). The unmapped value is still stored for reg_dout.
- reg_dout is always the raw last-written value. It is combinational from the register and is independent of reg_read.
- States:
  - IDLE
  - START: down-counter from START_DELAY-1.
  - XFER: byte index idx 0..NBYTES-1 and phase ph 0..TPB-1.
- Transitions:
  - IDLE --reg_write--> START.
  - START, count 0 --> XFER with idx=0, ph=0.
  - XFER, ph=TPB-1 and idx=NBYTES-1 --> IDLE.
  - Otherwise in XFER, ph increments; when ph wraps, idx increments.
- Restart: reg_write in START or XFER reloads src, returns to START with a full delay, and resets idx to 0. dma_active stays high throughout. Any pending wr_dma in that cycle is suppressed.
- dma_active: goes to 1 on the clock edge that samples reg_write. Stays 1 through START and XFER. Goes to 0 on the edge after the final OAM write. Total high time for one transfer is START_DELAY + NBYTES*TPB = 644 clocks.
- XFER outputs:
  - adr_dma_rd = {src_mapped, idx}, using idx[7:0] and zero-extending. The address holds stable for all TPB phases.
  - rd_dma=1 in phases 0..TPB-2.
  - data_dma_in is registered into data_dma_out at the end of phase TPB-2.
  - wr_dma=1 in phase TPB-1, with adr_dma_wr=idx.
- Outside XFER: rd_dma=0 and wr_dma=0. adr_dma_rd and adr_dma_wr hold their last values.
- dma_drvext=1 in START and XFER when src_mapped is outside 0x80..0x9F. When the source is VRAM, dma_drvext=0 and the top routes the read through csdma_vram.
- All outputs are registered, except reg_dout and the decode of dma_drvext from registered state.

Decomposition:
- Shared package/header holds:
  - DMA_REG_OFS = 4'h6 (offset of 0xFF46 in the PPU register block);
  - OAM_SIZE = 160;
  - VRAM_PAGE_LO = 8'h80, VRAM_PAGE_HI = 8'h9F;
  - ECHO_PAGE_LO = 8'hE0;
  - state encoding localparams IDLE, START, XFER.
- No sub-module. The state machine plus idx/ph counters form one block. The echo/VRAM page decode is a local function.

Test Plan:
- Write 0xC0, src RAM holds pattern i^0x5A -> the bench checks these timings and contents:
  - dma_active rises on the next clock;
  - first rd_dma with adr 0xC000 after 4 clocks;
  - 160 wr_dma pulses with adr 0x00..0x9F and data i^0x5A;
  - dma_active falls after 644 clocks;
  - dma_drvext=1 throughout.
- Write 0x80 -> adr_dma_rd runs 0x8000..0x809F, dma_drvext stays 0, OAM contents match VRAM.
- Write 0xFE -> reads come from 0xDE00..0xDE9F, and reg_dout reads 0xFE.
- Write 0xC0, then write 0xD0 at idx=50 ph=1 -> no write for idx 50, a 4-clock delay follows, the transfer restarts at 0xD000, dma_active never drops, and the final OAM holds the 0xD0 page.
- Assert reset at idx=80 -> on the next clock all outputs are 0 and the state is IDLE. OAM 0..79 are updated and 80..159 are untouched. A subsequent write starts cleanly.
- Write 0x00 -> adr_dma_rd runs 0x0000..0x009F, dma_drvext=1, and exactly 160 writes occur.
